// File: rtl/nes_pkg.sv
// Shared NES-core types and register addresses.
// The OAM DMA trigger register address lives here so the CPU register-file decode and the DMA agree on it.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } oam_dma_state_t;

    localparam logic [15:0] OAMDMA_REG = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a $4014 write, halt the CPU and copy page $XX00-$XXFF into OAM through its auto-increment port.
// Stall is 513 or 514 CPU cycles depending on halt-cycle parity; all sequencing advances only on cpu_ce.
module oam_dma
    import nes_pkg::*;
#(
    parameter int OAM_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic        dma_wr,
    input  logic [7:0]  dma_page,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_data_i,
    output logic        cpu_rdy,
    output logic        bus_own,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic [7:0]  oam_data,
    output logic        oam_wr,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    oam_dma_state_t state;
    oam_dma_state_t state_nxt;

    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;

    logic       page_ld;
    logic       idx_inc;
    logic       latch_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        page_ld   = 1'b0;
        idx_inc   = 1'b0;
        latch_ld  = 1'b0;
        bus_own   = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = 16'h0000;
        oam_wr    = 1'b0;
        oam_data  = 8'h00;

        case (state)
            IDLE: begin
                // Acceptance does not wait for cpu_ce; a coincident cpu_ce only toggles parity.
                if (dma_wr) begin
                    page_ld   = 1'b1;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // The 6502 only stops on a read cycle; halt-cycle parity decides whether an align cycle is needed.
                if (cpu_ce && cpu_rw) begin
                    state_nxt = parity ? READ : ALIGN;
                end
            end
            ALIGN: begin
                if (cpu_ce) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                bus_own  = 1'b1;
                bus_rd   = 1'b1;
                bus_addr = {page, idx};
                if (cpu_ce) begin
                    latch_ld  = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                oam_wr   = cpu_ce;
                oam_data = latch;
                if (cpu_ce) begin
                    idx_inc   = 1'b1;
                    state_nxt = (idx == LAST_IDX) ? IDLE : READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cpu_rdy = (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            latch  <= 8'h00;
        end else begin
            parity <= parity ^ cpu_ce;
            if (page_ld) begin
                page <= dma_page;
                idx  <= 8'h00;
            end else if (idx_inc) begin
                idx <= idx + 8'h01;
            end
            if (latch_ld) begin
                latch <= bus_data_i;
            end
        end
    end

endmodule
